// File: rtl/alu_bus_sequencer_if.sv
// alu_bus_sequencer_if: request, ALU bus and response signals of the ALU sequencer
interface alu_bus_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] req_c;
    logic       alu_reset;
    logic       alu_begin;
    logic [1:0] alu_op_code;
    logic [7:0] alu_inbus;
    logic [7:0] alu_outbus;
    logic       alu_end;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_hi;
    logic [7:0] rsp_lo;
    logic       rsp_timeout;
    logic       busy;
    modport master (
        input  req_valid, req_op, req_a, req_b, req_c, alu_outbus, alu_end, rsp_ready,
        output req_ready, alu_reset, alu_begin, alu_op_code, alu_inbus,
               rsp_valid, rsp_hi, rsp_lo, rsp_timeout, busy
    );
    modport slave (
        output req_valid, req_op, req_a, req_b, req_c, alu_outbus, alu_end, rsp_ready,
        input  req_ready, alu_reset, alu_begin, alu_op_code, alu_inbus,
               rsp_valid, rsp_hi, rsp_lo, rsp_timeout, busy
    );
endinterface

// File: rtl/alu_bus_sequencer.sv
// alu_bus_sequencer: feeds one request's operands to the sequential ALU and returns its result
module alu_bus_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_W         = 8
) (
    input logic clk,
    input logic reset,
    alu_bus_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, LOAD, WAIT, ABORT, HOLD} state_t;
    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d, k_q, k_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, prev_q, prev_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [7:0]        wd_q, wd_d;
    logic              to_q, to_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            prev_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            prev_q  <= prev_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        prev_d  = prev_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wd_d    = wd_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                op_d    = bus.req_op;
                a_d     = bus.req_a;
                b_d     = bus.req_b;
                c_d     = bus.req_c;
                state_d = START;
            end
            START: begin
                k_d     = '0;
                state_d = LOAD;
            end
            LOAD: begin
                k_d = k_q + 2'd1;
                if (k_q == (op_q == 2'b11 ? 2'd2 : 2'd1)) begin
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                prev_d = bus.alu_outbus;
                wd_d   = wd_q + 8'd1;
                // The ALU presents A one cycle before END and Q on the END cycle
                if (bus.alu_end) begin
                    hi_d    = op_q[1] ? prev_q : '0;
                    lo_d    = bus.alu_outbus;
                    to_d    = 1'b0;
                    state_d = HOLD;
                end else if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                hi_d    = '0;
                lo_d    = '0;
                to_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (bus.rsp_ready) begin
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.req_ready   = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.alu_reset   = reset | (state_q == ABORT);
    assign bus.alu_begin   = state_q == START;
    assign bus.alu_op_code = state_q == IDLE ? 2'b00 : op_q;
    assign bus.alu_inbus   = state_q != LOAD ? '0 : k_q == 2'd0 ? a_q : k_q == 2'd1 ? b_q : c_q;
    assign bus.rsp_valid   = state_q == HOLD;
    assign bus.rsp_hi      = hi_q;
    assign bus.rsp_lo      = lo_q;
    assign bus.rsp_timeout = to_q;
endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb_alu_bus_sequencer: table-driven vectors plus reset sequences against an ALU bus stub
module tb_alu_bus_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    alu_bus_sequencer_if bus();
    alu_bus_sequencer #(.TIMEOUT_CYCLES(8), .DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        int         dly;
        int         hold;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       to;
    } vec_t;
    vec_t v[9];
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // ALU stub: computes {A,Q} from the words actually seen on inbus
    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        logic [15:0] dvd;
        dvd = {w0, w1};
        case (op)
            2'd0: alu_model = {8'h00, w0 + w1};
            2'd1: alu_model = {8'h00, w0 - w1};
            2'd2: alu_model = 16'(w0 * w1);
            default: alu_model = {8'(dvd % 16'(w2)), 8'(dvd / 16'(w2))};
        endcase
    endfunction
    task automatic start_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input int nl, output logic [7:0] w0, output logic [7:0] w1, output logic [7:0] w2);
        logic [7:0] w[3];
        w = '{8'h00, 8'h00, 8'h00};
        @(negedge clk);
        chk("req_ready_idle", 16'(bus.req_ready), 16'd1);
        chk("busy_idle", 16'(bus.busy), 16'd0);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_c = c;
        bus.alu_end = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a = 8'hEE;
        bus.req_b = 8'hEE;
        bus.req_c = 8'hEE;
        chk("begin_start", 16'(bus.alu_begin), 16'd1);
        chk("opcode_start", 16'(bus.alu_op_code), 16'(op));
        chk("inbus_start", 16'(bus.alu_inbus), 16'd0);
        chk("req_ready_busy", 16'(bus.req_ready), 16'd0);
        for (int k = 0; k < nl; k++) begin
            @(negedge clk);
            chk("begin_load", 16'(bus.alu_begin), 16'd0);
            chk("inbus_load", 16'(bus.alu_inbus), 16'(k == 0 ? a : k == 1 ? b : c));
            w[k] = bus.alu_inbus;
        end
        w0 = w[0];
        w1 = w[1];
        w2 = w[2];
    endtask
    task automatic run(input vec_t t);
        logic [7:0] w0, w1, w2;
        logic [15:0] r;
        int abort_at, aborts, resp_at;
        start_op(t.op, t.a, t.b, t.c, t.op == 2'd3 ? 3 : 2, w0, w1, w2);
        r = alu_model(t.op, w0, w1, w2);
        abort_at = -1;
        aborts = 0;
        resp_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.alu_reset) begin
                aborts++;
                if (abort_at < 0) abort_at = i;
            end
            if (bus.rsp_valid) begin
                resp_at = i;
                break;
            end
            bus.alu_end = t.dly != 0 && i == t.dly - 1;
            bus.alu_outbus = (t.dly != 0 && i == t.dly - 1) ? r[7:0] : (t.dly != 0 && i == t.dly - 2) ? r[15:8] : 8'hA5;
        end
        bus.alu_end = 1'b0;
        bus.alu_outbus = 8'h5A;
        chk("resp_latency", 16'(resp_at), 16'(t.dly != 0 ? t.dly : 9));
        chk("abort_cycles", 16'(aborts), 16'(t.to ? 1 : 0));
        if (t.to) chk("abort_at", 16'(abort_at), 16'd8);
        chk("rsp_hi", 16'(bus.rsp_hi), 16'(t.hi));
        chk("rsp_lo", 16'(bus.rsp_lo), 16'(t.lo));
        chk("rsp_timeout", 16'(bus.rsp_timeout), 16'(t.to));
        chk("opcode_hold", 16'(bus.alu_op_code), 16'(t.op));
        for (int h = 0; h < t.hold; h++) begin
            bus.req_valid = 1'b1;
            bus.req_op = ~t.op;
            @(negedge clk);
            chk("bp_valid", 16'(bus.rsp_valid), 16'd1);
            chk("bp_data", {bus.rsp_hi, bus.rsp_lo}, {t.hi, t.lo});
            chk("bp_req_ready", 16'(bus.req_ready), 16'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("post_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("post_timeout", 16'(bus.rsp_timeout), 16'd0);
        chk("post_req_ready", 16'(bus.req_ready), 16'd1);
        chk("post_busy", 16'(bus.busy), 16'd0);
        chk("post_opcode", 16'(bus.alu_op_code), 16'd0);
    endtask
    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_alu_reset_async"}, 16'(bus.alu_reset), 16'd1);
        @(negedge clk);
        chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_req_ready"}, 16'(bus.req_ready), 16'd1);
        chk({tag, "_opcode"}, 16'(bus.alu_op_code), 16'd0);
        chk({tag, "_alu_reset"}, 16'(bus.alu_reset), 16'd1);
        reset = 1'b0;
        bus.alu_end = 1'b0;
        #1;
        chk({tag, "_alu_reset_off"}, 16'(bus.alu_reset), 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_no_rsp"}, 16'(bus.rsp_valid), 16'd0);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation hung");
    end
    initial begin
        logic [7:0] w0, w1, w2;
        v[0] = '{2'd0, 8'h05, 8'h03, 8'h00, 3, 0, 8'h00, 8'h08, 1'b0};
        v[1] = '{2'd1, 8'h05, 8'h03, 8'h00, 2, 0, 8'h00, 8'h02, 1'b0};
        v[2] = '{2'd2, 8'h0C, 8'h0A, 8'h00, 5, 0, 8'h00, 8'h78, 1'b0};
        v[3] = '{2'd3, 8'h00, 8'h64, 8'h07, 6, 0, 8'h02, 8'h0E, 1'b0};
        v[4] = '{2'd2, 8'hFF, 8'hFF, 8'h00, 8, 0, 8'hFE, 8'h01, 1'b0};
        v[5] = '{2'd0, 8'h7F, 8'h01, 8'h00, 1, 0, 8'h00, 8'h80, 1'b0};
        v[6] = '{2'd2, 8'h12, 8'h34, 8'h00, 0, 2, 8'h00, 8'h00, 1'b1};
        v[7] = '{2'd3, 8'h01, 8'h00, 8'h10, 4, 0, 8'h00, 8'h10, 1'b0};
        v[8] = '{2'd1, 8'h03, 8'h05, 8'h00, 2, 5, 8'h00, 8'hFE, 1'b0};
        bus.req_valid = 1'b0;
        bus.req_op = 2'd0;
        bus.req_a = 8'h00;
        bus.req_b = 8'h00;
        bus.req_c = 8'h00;
        bus.alu_outbus = 8'h00;
        bus.alu_end = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 16'(bus.req_ready), 16'd1);
        chk("rst_begin", 16'(bus.alu_begin), 16'd0);
        chk("rst_opcode", 16'(bus.alu_op_code), 16'd0);
        chk("rst_inbus", 16'(bus.alu_inbus), 16'd0);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
        chk("rst_rsp_data", {bus.rsp_hi, bus.rsp_lo}, 16'h0000);
        chk("rst_timeout", 16'(bus.rsp_timeout), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_alu_reset", 16'(bus.alu_reset), 16'd1);
        reset = 1'b0;
        #1;
        chk("rel_alu_reset", 16'(bus.alu_reset), 16'd0);
        for (int n = 0; n < 9; n++) run(v[n]);
        start_op(2'd2, 8'h11, 8'h22, 8'h00, 1, w0, w1, w2);
        reset_pulse("rst_load");
        start_op(2'd3, 8'h00, 8'h64, 8'h07, 3, w0, w1, w2);
        repeat (3) begin
            @(negedge clk);
            bus.alu_end = 1'b0;
            bus.alu_outbus = 8'hA5;
        end
        reset_pulse("rst_wait");
        run(v[5]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_bus_sequencer.md
Name: alu_bus_sequencer

Overview:
Upstream driver for the 8-bit sequential ALU (add/sub, Radix-4 multiply, SRT-2 divide). It accepts one operation request over a valid/ready handshake and pulses BEGIN with a stable op_code. It then serialises the operands onto the ALU inbus in the fixed load order and captures the result words from the ALU outbus. It returns the result over a second valid/ready handshake, and a watchdog aborts and resets the ALU if END never arrives.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT without alu_end before abort (1..255)
DATA_W, 8, operand/result word width; fixed at 8 to match the ALU bus

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  2  00 add, 01 sub, 10 multiply, 11 divide
req_a  in  8  add/sub: first operand; mul: multiplicand Q; div: dividend high (A)
req_b  in  8  add/sub: second operand (M); mul: multiplier (M); div: dividend low (Q)
req_c  in  8  div: divisor (M); ignored otherwise
alu_reset  out  1  reset to ALU
alu_begin  out  1  BEGIN pulse
alu_op_code  out  2  op_code to ALU
alu_inbus  out  8  ALU inbus
alu_outbus  in  8  ALU outbus
alu_end  in  1  ALU END
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_hi  out  8  mul: product high (A); div: remainder (A); add/sub: 0
rsp_lo  out  8  mul: product low (Q); div: quotient (Q); add/sub: result
rsp_timeout  out  1  response is an abort, data 0
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; req_ready=1; alu_begin=0; alu_op_code=00; alu_inbus=0; rsp_valid=0; rsp_hi=rsp_lo=0; rsp_timeout=0; busy=0. alu_reset=1 whenever reset=1.
- alu_reset = reset | (state==ABORT). It is registered for the ABORT term and combinational for the reset term.
- FSM states:
  - IDLE: req_ready=1. On accept at cycle T, latch op/a/b/c, go to START.
  - START (T+1): alu_begin=1, alu_op_code=latched op, alu_inbus=0.
  - LOAD (T+2 onward): word counter k=0..N-1 drives one word per cycle. N=2 for ops 00/01/10, with word order a,b. N=3 for op 11, with word order a,b,c. After the last word, go to WAIT with the watchdog cleared.
  - WAIT: alu_inbus=0. Each cycle, prev <= alu_outbus and the watchdog increments.
    - On alu_end=1, capture: op 10/11 gives rsp_hi=prev and rsp_lo=alu_outbus (the ALU pushes A the cycle before END and Q on the END cycle); op 00/01 gives rsp_hi=0 and rsp_lo=alu_outbus. Go to HOLD.
    - If the watchdog reaches TIMEOUT_CYCLES-1 with alu_end=0, go to ABORT.
  - ABORT: one cycle with alu_reset=1; set rsp_timeout=1 and rsp_hi=rsp_lo=0; go to HOLD.
  - HOLD: rsp_valid=1, data stable. On rsp_ready, go to IDLE and clear rsp_valid and rsp_timeout the next cycle.
- alu_op_code stays at the latched op from START through HOLD. It returns to 00 only in IDLE, because the ALU datapath uses op_code combinationally during the whole operation.
- req_ready=0 in every state except IDLE. There is no request queue and no back-to-back acceptance in HOLD.
- alu_end is ignored outside WAIT. If alu_end and watchdog expiry occur in the same cycle, END wins and the result is normal.
- Synchronous reset in any state returns to IDLE next edge, asserts alu_reset that cycle, and drops any pending response.
- alu_outbus is sampled as plain data: the ALU's high-Z is never interpreted, only cycle position is used.
- Minimum request-to-response latency = 2 + N + cycles-to-END.

Test Plan:
- Add: req_op=00, a=05, b=03; ALU ends with outbus 08 -> inbus 05 at T+2, 03 at T+3; begin high only at T+1; rsp_hi=00, rsp_lo=08, rsp_timeout=0.
- Multiply: op=10, a=0C, b=0A, against the integrated ALU -> rsp_hi=00, rsp_lo=78; alu_op_code=10 held from T+1 until the rsp handshake.
- Divide: op=11, a=00, b=64, c=07 -> inbus sequence 00,64,07; rsp_hi=02 (remainder), rsp_lo=0E (quotient).
- Timeout: TIMEOUT_CYCLES=8, ALU stub never raises END -> alu_reset high exactly one cycle 8 cycles after WAIT entry; rsp_valid with rsp_timeout=1 and data 00/00.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable; req_ready=0 throughout; a second req_valid is not accepted until the cycle after rsp handshake.
- Reset mid-LOAD and mid-WAIT -> IDLE next cycle, alu_reset=1 during reset, no rsp_valid; a following add 7F+01 returns 80.
